ringer_module: RTL and testbench

RINGER_MODULE -- requirements
Module: ringer_module

---
 rtl/ringer_module.sv | 62 ++++++
 tb/tb_ringer_module.sv | 109 ++++++++++
 2 files changed

// File: rtl/ringer_module.sv
// ringer_module: call alert FSM steering ringer or motor; RINGER_CADENCE_EN adds an ON/OFF cadence.
module ringer_module #(
  parameter int ON_CYCLES  = 4,
  parameter int OFF_CYCLES = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic ring,
  input  logic vibrate_mode,
  output logic ringer,
  output logic motor,
  output logic active
);
  typedef enum logic [1:0] {IDLE, RING, VIBRATE} state_t;
  state_t state, nxt;
  if (ON_CYCLES < 1 || ON_CYCLES > 65535 || OFF_CYCLES < 1 || OFF_CYCLES > 65535) begin : g_chk
    $error("ringer_module: ON_CYCLES/OFF_CYCLES out of range");
  end
  always_comb nxt = !ring ? IDLE : vibrate_mode ? VIBRATE : RING;
`ifdef RINGER_CADENCE_EN
  logic [15:0] cnt, cnt_nxt;
  logic off, off_nxt, restart, end_ph;
  // entering or swapping state restarts the cadence at the ON phase
  always_comb begin
    restart = (nxt != state) || (nxt == IDLE);
    end_ph  = cnt == (off ? 16'(OFF_CYCLES - 1) : 16'(ON_CYCLES - 1));
    off_nxt = restart ? 1'b0 : end_ph ? ~off : off;
    cnt_nxt = (restart || end_ph) ? 16'd0 : cnt + 16'd1;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      cnt    <= '0;
      off    <= 1'b0;
      ringer <= 1'b0;
      motor  <= 1'b0;
      active <= 1'b0;
    end else begin
      state  <= nxt;
      cnt    <= cnt_nxt;
      off    <= off_nxt;
      ringer <= (nxt == RING) && !off_nxt;
      motor  <= (nxt == VIBRATE) && !off_nxt;
      active <= nxt != IDLE;
    end
  end
`else
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      ringer <= 1'b0;
      motor  <= 1'b0;
      active <= 1'b0;
    end else begin
      state  <= nxt;
      ringer <= nxt == RING;
      motor  <= nxt == VIBRATE;
      active <= nxt != IDLE;
    end
  end
`endif
endmodule

// File: tb/tb_ringer_module.sv
// tb_ringer_module: randomized/directed stimulus, queue scoreboard against a cadence-aware reference model.
module tb_ringer_module;
  localparam int ON = 3;
  localparam int OFF = 2;
  logic clk = 1'b0, rst_n = 1'b0, ring = 1'b0, vibrate_mode = 1'b0;
  logic ringer, motor, active;
  int n_cmp = 0, n_bad = 0;
  logic [2:0] exp_q[$];
  ringer_module #(.ON_CYCLES(ON), .OFF_CYCLES(OFF)) dut (
    .clk(clk), .rst_n(rst_n), .ring(ring), .vibrate_mode(vibrate_mode),
    .ringer(ringer), .motor(motor), .active(active)
  );
  always #5 clk = ~clk;

  // reference: mode chosen by inputs, k = cycles spent in the current alert mode
  int mstate = 0, k = 0;
  always @(posedge clk) begin
    int nm;
    bit on;
    if (!rst_n) begin
      mstate = 0;
      k = 0;
      exp_q.push_back(3'b000);
    end else begin
      nm = !ring ? 0 : vibrate_mode ? 2 : 1;
      k = (nm != mstate) ? 0 : k + 1;
      mstate = nm;
`ifdef RINGER_CADENCE_EN
      on = (k % (ON + OFF)) < ON;
`else
      on = 1'b1;
`endif
      exp_q.push_back({nm == 1 && on, nm == 2 && on, nm != 0});
    end
  end

  always @(posedge clk) begin
    logic [2:0] e;
    #1;
    n_cmp++;
    if (exp_q.size() == 0) begin
      n_bad++;
      $display("FAIL scoreboard_empty: no expected entry at %0t", $time);
    end else begin
      e = exp_q.pop_front();
      if ({ringer, motor, active} != e) begin
        n_bad++;
        $display("FAIL outputs at %0t: {ringer,motor,active}=%b required %b", $time, {ringer, motor, active}, e);
      end
    end
    n_cmp++;
    if (ringer && motor) begin
      n_bad++;
      $display("FAIL exclusive at %0t: ringer=%b motor=%b required not both 1", $time, ringer, motor);
    end
  end

  task automatic drive(input logic r, input logic v, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      ring = r;
      vibrate_mode = v;
    end
  endtask

  initial begin
    #2;
    n_cmp++;
    if ({ringer, motor, active} != 3'b000) begin
      n_bad++;
      $display("FAIL reset_state: %b required 000", {ringer, motor, active});
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    drive(0, 0, 10);
    drive(0, 1, 10);
    drive(1, 0, 10);
    drive(1, 1, 10);
    drive(1, 0, 7);
    drive(1, 1, 4);
    drive(1, 0, 2);
    drive(0, 0, 3);
    drive(1, 1, 3);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (motor !== 1'b0 || active !== 1'b0) begin
      n_bad++;
      $display("FAIL async_reset: motor=%b active=%b required 0 0", motor, active);
    end
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      logic r, v;
      r = ($urandom_range(0, 3) != 0);
      v = ($urandom_range(0, 5) == 0) ? ~vibrate_mode : vibrate_mode;
      drive(r, v, 1);
    end
    drive(0, 0, 3);
    @(posedge clk);
    #2;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
